// File: rtl/dsp_out_misr.sv
// dsp_out_misr: folds the DSP result bus into a MISR over len cycles, then shifts the signature out MSB first.
// Build option DSP_MISR_PARITY_EN adds a held result register and its parity on the parity port.
module dsp_out_misr #(
    parameter int                   DIN_WIDTH = 128,
    parameter int                   SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0] POLY      = 32'h04C11DB7,
    parameter logic [SIG_WIDTH-1:0] SEED      = 32'hFFFFFFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] din,
    input  logic                 start,
    input  logic [15:0]          len,
    output logic                 busy,
    output logic                 sout,
    output logic                 sout_valid,
    output logic                 done,
    output logic                 parity
);

    localparam int          NSLICE     = DIN_WIDTH / SIG_WIDTH;
    localparam logic [15:0] SHIFT_LAST = 16'(SIG_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SHIFT, DONE} state_t;

    state_t               state_q, state_d;
    logic [SIG_WIDTH-1:0] sig_q, sig_d;
    logic [SIG_WIDTH-1:0] fold;
    logic [SIG_WIDTH-1:0] sig_step;
    logic [15:0]          cnt_q, cnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fold = '0;
        for (int i = 0; i < NSLICE; i++) begin
            fold ^= din[i*SIG_WIDTH +: SIG_WIDTH];
        end
    end

    assign sig_step = {sig_q[SIG_WIDTH-2:0], 1'b0}
                    ^ (sig_q[SIG_WIDTH-1] ? POLY : '0)
                    ^ fold;

    always_comb begin
        state_d    = state_q;
        sig_d      = sig_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sig_d = SEED;
                    if (len != 16'd0) begin
                        state_d = ACCUM;
                        cnt_d   = len;
                    end else begin
                        state_d = SHIFT;
                        cnt_d   = SHIFT_LAST;
                    end
                end
            end
            ACCUM: begin
                busy  = 1'b1;
                sig_d = sig_step;
                // cnt holds the updates still owed, including this one
                if (cnt_q == 16'd1) begin
                    state_d = SHIFT;
                    cnt_d   = SHIFT_LAST;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            SHIFT: begin
                busy       = 1'b1;
                sout       = sig_q[SIG_WIDTH-1];
                sout_valid = 1'b1;
                sig_d      = {sig_q[SIG_WIDTH-2:0], 1'b0};
                if (cnt_q == 16'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sig_q   <= SEED;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DSP_MISR_PARITY_EN
    logic [SIG_WIDTH-1:0] result_q, result_d;
    logic                 parity_q, parity_d;

    // Snapshot the finished signature before SHIFT starts consuming sig.
    always_comb begin
        result_d = result_q;
        parity_d = parity_q;
        if (state_d == SHIFT && state_q != SHIFT) begin
            result_d = sig_d;
            parity_d = ^sig_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= SEED;
            parity_q <= 1'b0;
        end else begin
            result_q <= result_d;
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_out_misr.sv
// Self-checking bench for dsp_out_misr: table vectors, multi-cycle corner sequences and
// randomized runs compared against an arithmetic reference of the MISR rules.
module tb_dsp_out_misr;

    localparam logic [31:0] POLY_C = 32'h04C11DB7;
    localparam logic [31:0] SEED_C = 32'hFFFFFFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] din;
    logic         start;
    logic [15:0]  len;
    logic         busy, sout, sout_valid, done, parity;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] din_seq[$];

    dsp_out_misr dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done),
        .parity     (parity)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]  len;
        logic [127:0] din;
        logic [31:0]  exp_sig;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_sig(input int n);
        logic [31:0] s;
        logic [31:0] f;
        s = SEED_C;
        for (int k = 0; k < n; k++) begin
            f = din_seq[k][127:96] ^ din_seq[k][95:64] ^ din_seq[k][63:32] ^ din_seq[k][31:0];
            s = (s << 1) ^ (s[31] ? POLY_C : 32'h0) ^ f;
        end
        return s;
    endfunction

    function automatic logic exp_parity(input logic [31:0] s);
`ifdef DSP_MISR_PARITY_EN
        return ^s;
`else
        return 1'b0 & s[0];
`endif
    endfunction

    // One full run; din_seq supplies the accumulate samples in order.
    task automatic run_check(input string name, input logic [15:0] l, input logic [31:0] exp_sig,
                             input bit pulse_start, input bit scramble_len);
        logic [31:0] shreg;
        int          n_valid, first_valid, done_cyc, busy_cnt, limit;
        logic        par_seen;
        shreg = 32'h0; n_valid = 0; first_valid = -1; done_cyc = -1; busy_cnt = 0;
        par_seen = 1'bx;
        limit = int'(l) + 40;
        @(negedge clk);
        start = 1'b1;
        len   = l;
        for (int cyc = 1; cyc <= limit && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (!pulse_start) start = 1'b0;
            if (scramble_len) len = 16'($urandom);
            din = (cyc - 1 < din_seq.size()) ? din_seq[cyc-1]
                                             : {$urandom, $urandom, $urandom, $urandom};
            if (cyc == 1) check({name, " busy_rise"}, 32'(busy), 32'd1);
            if (busy) busy_cnt++;
            if (sout_valid) begin
                if (first_valid < 0) first_valid = cyc;
                n_valid++;
                shreg = {shreg[30:0], sout};
            end
            if (done) begin
                done_cyc = cyc;
                par_seen = parity;
            end
        end
        check({name, " first_valid"}, 32'(first_valid), 32'(int'(l) + 1));
        check({name, " valid_cnt"},   32'(n_valid),     32'd32);
        check({name, " signature"},   shreg,            exp_sig);
        check({name, " done_cyc"},    32'(done_cyc),    32'(int'(l) + 33));
        check({name, " busy_cnt"},    32'(busy_cnt),    32'(int'(l) + 33));
        check({name, " parity"},      32'(par_seen),    32'(exp_parity(exp_sig)));
        @(negedge clk);
        check({name, " post_done"}, {30'h0, busy, done}, 32'h0);
        start = 1'b0;
    endtask

    initial begin
        int          n_sv, n_done;
        logic [15:0] rl;

        rst = 1'b1; start = 1'b0; len = 16'h0; din = '0;
        vecs[0] = '{16'd0, 128'h0, 32'hFFFFFFFF};
        vecs[1] = '{16'd1, 128'h0, 32'hFB3EE249};
        vecs[2] = '{16'd1, {32'h1, 32'h1, 64'h0}, 32'hFB3EE249};
        vecs[3] = '{16'd1, {96'h0, 32'h1}, 32'hFB3EE248};
        vecs[4] = '{16'd2, 128'h0, 32'hF2BCD925};

        repeat (2) @(negedge clk);
        check("reset_outputs", {27'h0, busy, sout, sout_valid, done, parity}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", {27'h0, busy, sout, sout_valid, done, parity}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            din_seq.delete();
            for (int k = 0; k < int'(vecs[i].len); k++) din_seq.push_back(vecs[i].din);
            run_check($sformatf("vec%0d", i), vecs[i].len, vecs[i].exp_sig, 1'b0, 1'b0);
        end

        // start held high through a len=4 run must give one run with the same signature
        din_seq.delete();
        for (int k = 0; k < 4; k++) din_seq.push_back({$urandom, $urandom, $urandom, $urandom});
        run_check("len4_single", 16'd4, model_sig(4), 1'b0, 1'b0);
        run_check("len4_pulsed", 16'd4, model_sig(4), 1'b1, 1'b0);

        // reset during the 10th SHIFT cycle discards the run
        din_seq.delete();
        @(negedge clk);
        start = 1'b1; len = 16'd0;
        n_sv = 0;
        for (int cyc = 0; cyc < 40 && n_sv < 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (sout_valid) n_sv++;
        end
        check("rst_reach_shift10", 32'(n_sv), 32'd10);
        rst = 1'b1;
        #1;
        check("rst_midrun_outputs", {27'h0, busy, sout, sout_valid, done, parity}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done || busy) n_done++;
        end
        check("rst_no_done", 32'(n_done), 32'd0);
        run_check("after_rst_len0", 16'd0, 32'hFFFFFFFF, 1'b0, 1'b0);

        // random din, len=100, len input scrambled during the run
        din_seq.delete();
        for (int k = 0; k < 100; k++) din_seq.push_back({$urandom, $urandom, $urandom, $urandom});
        run_check("rand_len100", 16'd100, model_sig(100), 1'b0, 1'b1);

        for (int r = 0; r < 3; r++) begin
            rl = 16'($urandom_range(60, 1));
            din_seq.delete();
            for (int k = 0; k < int'(rl); k++) din_seq.push_back({$urandom, $urandom, $urandom, $urandom});
            run_check($sformatf("rand%0d", r), rl, model_sig(int'(rl)), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
